// File: rtl/x32_approx_mul_seq_if.sv
// x32_approx_mul_seq_if: operand/result valid-ready bundle for the
// sequential 32x32 multiplier front-end.
interface x32_approx_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/x32_approx_mul_seq.sv
// x32_approx_mul_seq: 32x32 MUL/MULH/MULHSU/MULHU over four 16x16 passes.
// Define X32_MUL_SIGNED_EN for signed MULH/MULHSU; otherwise they act as MULHU.
module x16_approx_mul #(
  parameter int N16 = 0,
  parameter int N8  = 0,
  parameter int N4  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [31:0] p_q, p_d;
  logic [31:0] ll, lh, hl, hh, s0, s1;

  // Lower-part-OR adder: n LSBs are OR-ed, carry-in guessed from bit n-1.
  function automatic logic [31:0] loa_add(
    input logic [31:0] x,
    input logic [31:0] y,
    input int          n
  );
    logic [31:0] m;
    logic [31:0] hi;
    logic        c;
    if (n <= 0)       m = '0;
    else if (n >= 32) m = '1;
    else              m = (32'd1 << n) - 32'd1;
    c  = |(x & y & (m ^ (m >> 1)));
    hi = (x & ~m) + (y & ~m) + (32'(c) << n);
    return (hi & ~m) | ((x | y) & m);
  endfunction

  function automatic logic [31:0] mul8(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [31:0] q0, q1, q2, q3, t0, t1;
    q0 = 32'(x[3:0]) * 32'(y[3:0]);
    q1 = 32'(x[3:0]) * 32'(y[7:4]);
    q2 = 32'(x[7:4]) * 32'(y[3:0]);
    q3 = 32'(x[7:4]) * 32'(y[7:4]);
    t0 = loa_add(q0, q3 << 8, N4);
    t1 = loa_add(q1, q2, N4);
    return loa_add(t0, t1 << 4, N4);
  endfunction

  always_comb begin
    ll  = mul8(a[7:0], b[7:0]);
    lh  = mul8(a[7:0], b[15:8]);
    hl  = mul8(a[15:8], b[7:0]);
    hh  = mul8(a[15:8], b[15:8]);
    s0  = loa_add(ll, hh << 16, N8);
    s1  = loa_add(lh, hl, N8);
    p_d = loa_add(s0, s1 << 8, N16);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  assign p = p_q;
endmodule

module x32_approx_mul_seq #(
  parameter int N16 = 0,
  parameter int N8  = 0,
  parameter int N4  = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  x32_approx_mul_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE, MUL, FIX, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  mode_q, mode_d;
  logic [63:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic        accept;
  logic        sub_rst;
  logic [15:0] sub_a, sub_b;
  logic [31:0] sub_p;
  logic [63:0] prod_sh;
  logic [63:0] fix_p;
  logic [31:0] mag_a, mag_b;

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign sub_rst = ~resetn;

`ifdef X32_MUL_SIGNED_EN
  logic sa, sb, neg_in;
  logic neg_q, neg_d;

  always_comb begin
    sa     = (bus.mode == 2'b01) || (bus.mode == 2'b10);
    sb     = (bus.mode == 2'b01);
    mag_a  = (sa && bus.op_a[31]) ? -bus.op_a : bus.op_a;
    mag_b  = (sb && bus.op_b[31]) ? -bus.op_b : bus.op_b;
    neg_in = (sa & bus.op_a[31]) ^ (sb & bus.op_b[31]);
    neg_d  = accept ? neg_in : neg_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) neg_q <= 1'b0;
    else         neg_q <= neg_d;
  end

  assign fix_p = neg_q ? -acc_q : acc_q;
`else
  assign mag_a = bus.op_a;
  assign mag_b = bus.op_b;
  assign fix_p = acc_q;
`endif

  // Pair issued this cycle; its product lands in sub_p one cycle later.
  always_comb begin
    sub_a = '0;
    sub_b = '0;
    if (state_q == MUL) begin
      unique case (cnt_q)
        3'd0: begin sub_a = a_q[15:0];  sub_b = b_q[15:0];  end
        3'd1: begin sub_a = a_q[15:0];  sub_b = b_q[31:16]; end
        3'd2: begin sub_a = a_q[31:16]; sub_b = b_q[15:0];  end
        3'd3: begin sub_a = a_q[31:16]; sub_b = b_q[31:16]; end
        default: begin sub_a = '0; sub_b = '0; end
      endcase
    end
  end

  always_comb begin
    unique case (cnt_q)
      3'd1:       prod_sh = {32'd0, sub_p};
      3'd2, 3'd3: prod_sh = {16'd0, sub_p, 16'd0};
      3'd4:       prod_sh = {sub_p, 32'd0};
      default:    prod_sh = '0;
    endcase
  end

  x16_approx_mul #(
    .N16 (N16),
    .N8  (N8),
    .N4  (N4)
  ) u_sub (
    .clk   (clk),
    .reset (sub_rst),
    .a     (sub_a),
    .b     (sub_b),
    .p     (sub_p)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = mag_a;
          b_d     = mag_b;
          mode_d  = bus.mode;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + prod_sh;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        res_d   = (mode_q == 2'b00) ? fix_p[31:0] : fix_p[63:32];
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
endmodule

// File: tb/tb_x32_approx_mul_seq.sv
// tb_x32_approx_mul_seq: directed corner cases plus random ops
// checked against a 64-bit arithmetic reference.
module tb_x32_approx_mul_seq;
  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  x32_approx_mul_seq_if bif ();

  x32_approx_mul_seq #(
    .N16 (0),
    .N8  (0),
    .N4  (0)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] m,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    bit          sa, sb;
    sa = 1'b0;
    sb = 1'b0;
`ifdef X32_MUL_SIGNED_EN
    sa = (m == 2'd1) || (m == 2'd2);
    sb = (m == 2'd1);
`endif
    ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (m == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic do_op(input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b, input bit pre,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    bif.in_valid  = 1'b1;
    bif.mode      = m;
    bif.op_a      = a;
    bif.op_b      = b;
    bif.out_ready = pre;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    lat = 0;
    while (!bif.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bif.result;
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] m,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit pre);
    logic [31:0] res;
    int          lat;
    do_op(m, a, b, pre, res, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd6);
    chk(tag, {32'd0, res}, {32'd0, exp});
    chk({tag, "_rdy"}, {63'd0, bif.in_ready}, 64'd1);
  endtask

  logic [31:0] corners [5];
  logic [31:0] hold;
  logic [31:0] ra, rb;
  logic [1:0]  rm;
  int          w;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    resetn        = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.mode      = 2'd0;
    bif.op_a      = '0;
    bif.op_b      = '0;
    #12;
    chk("rst_in_ready", {63'd0, bif.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bif.out_valid}, 64'd0);
    chk("rst_result", {32'd0, bif.result}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run("mul_shift", 2'd0, 32'h0001_2345, 32'h0001_0000,
        32'h2345_0000, 1'b0);
    run("mul_ones", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0000_0001, 1'b0);
    run("mulhu_ones", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 1'b1);
    run("mulh_min", 2'd1, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 1'b0);
`ifdef X32_MUL_SIGNED_EN
    run("mulh_ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0000_0000, 1'b0);
    run("mulhsu", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002,
        32'hFFFF_FFFF, 1'b0);
`else
    run("mulh_ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 1'b0);
    run("mulhsu", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002,
        32'h0000_0001, 1'b0);
`endif

    // Backpressure: result held, new request not taken while in DONE.
    @(negedge clk);
    bif.in_valid  = 1'b1;
    bif.mode      = 2'd3;
    bif.op_a      = 32'hFFFF_FFFF;
    bif.op_b      = 32'hFFFF_FFFF;
    bif.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    w = 0;
    while (!bif.out_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_lat", 64'(w), 64'd6);
    hold = bif.result;
    chk("bp_first", {32'd0, hold}, 64'h0000_0000_FFFF_FFFE);
    bif.in_valid = 1'b1;
    bif.mode     = 2'd0;
    bif.op_a     = 32'h0000_0003;
    bif.op_b     = 32'h0000_0005;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_result", {32'd0, bif.result}, {32'd0, hold});
      chk("bp_valid", {63'd0, bif.out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, bif.in_ready}, 64'd0);
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    chk("bp_release_rdy", {63'd0, bif.in_ready}, 64'd1);
    chk("bp_release_vld", {63'd0, bif.out_valid}, 64'd0);

    // Asynchronous reset mid-computation.
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.mode     = 2'd0;
    bif.op_a     = 32'h0000_0005;
    bif.op_b     = 32'h0000_0007;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, bif.out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, bif.in_ready}, 64'd1);
    chk("arst_result", {32'd0, bif.result}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run("post_rst", 2'd3, 32'h0001_0000, 32'h0001_0000,
        32'h0000_0001, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ?
           corners[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ?
           corners[$urandom_range(0, 4)] : 32'($urandom);
      run("rand", rm, ra, rb, ref_mul(rm, ra, rb),
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/x32_approx_mul_seq.md
# x32_approx_mul_seq

Sequential 32x32 multiplier front-end that feeds one `x16_approx_mul` instance four 16-bit operand pairs over consecutive cycles and accumulates the 16x16 partial products into a 64-bit result. It sits between the CPU-side issue logic and the 16-bit approximate multiplier. It supplies RISC-V M-extension style results (MUL/MULH/MULHSU/MULHU) over a valid/ready handshake. Approximation error is entirely inherited from the sub-multiplier. All accumulation and sign fix-up here is exact.

## Interface
- `N16`, default 0: approximate LSBs in the sub-multiplier's 32-bit adders; passed through.
- `N8`, default 0: approximate LSBs at the 8-bit level; passed through.
- `N4`, default 0: approximate LSBs at the 4-bit level; passed through.

- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset. Inverted and driven to the sub-multiplier's active-high `reset`.
- `in_valid`  in  1  operands and mode valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `op_a`  in  32  multiplicand.
- `op_b`  in  32  multiplier.
- `mode`  in  2  00 MUL (low 32), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  32  selected product half.

## Operation
- States: IDLE, MUL, FIX, DONE.
  - `in_ready` = (state == IDLE).
  - `out_valid` = (state == DONE).
- IDLE: on `in_valid && in_ready` at a clock edge:
  - Capture the magnitudes `|op_a|` and `|op_b|` as 32-bit unsigned. `|0x80000000|` = `0x80000000`.
  - Capture `neg = (sa & op_a[31]) ^ (sb & op_b[31])`. `sa` is 1 for modes 01 and 10. `sb` is 1 for mode 01.
  - Capture `mode`. Clear the 64-bit accumulator and step counter `cnt`. Go to MUL.
- MUL, `cnt` = 0..4: sub-multiplier inputs are selected combinationally from `cnt`.
  - 0: aL,bL
  - 1: aL,bH
  - 2: aH,bL
  - 3: aH,bH
  - 4: don't care (drive 0)
- Accumulation:
  - The sub-multiplier output reflects the pair issued in the previous cycle.
  - At each edge with `cnt` ≥ 1, add product[cnt-1] shifted left by 0, 16, 16 or 32 respectively.
  - At the `cnt`==4 edge, perform the final add and go to FIX.
- FIX:
  - Compute `p = neg ? -acc : acc` as 64-bit two's complement.
  - `result` <= `p[31:0]` for mode 00, otherwise `p[63:32]`. Go to DONE.
- DONE: `result` is held stable. On `out_ready`, go to IDLE.
- Inputs are ignored outside IDLE. No flush or abort except reset.
- Reset (asynchronous, any state):
  - State to IDLE, `out_valid` 0, `result` 0, accumulator 0, `cnt` 0.
  - `in_ready` is 1 while in reset.
  - The sub-multiplier registers clear at the same time.
- With N16=N8=N4=0 the result is bit-exact.

## Timing
- Latency: accept edge E → `out_valid` high after edge E+6. That is 5 MUL cycles plus 1 FIX cycle.
- Throughput:
  - Accept at E, result at E+6.
  - Handshake at the earliest at E+7.
  - Next accept at the earliest at E+8, since `in_ready` rises on entry to IDLE.
- `out_ready` may be high before `out_valid`. The handshake completes on the first DONE edge.
- Backpressure: `result` and `out_valid` are unchanged for any number of cycles with `out_ready` low.
- `in_valid` asserted during a busy period stalls at the producer. It is not queued.

## Configuration
- `X32_MUL_SIGNED_EN`:
  - Defined: modes 01 and 10 perform signed operand handling as above.
  - Undefined: `sa` = `sb` = 0, so modes 01 and 10 behave as MULHU. The absolute-value and negation logic is compiled out.
  - Mode 00 is identical in both builds.

## Test plan
All scenarios use N16=N8=N4=0.
- MUL `0x00012345`×`0x00010000` → `result` `0x23450000`; `out_valid` exactly 6 edges after the accept edge.
- `0xFFFFFFFF`×`0xFFFFFFFF`: MUL → `0x00000001`; MULHU → `0xFFFFFFFE`.
- MULH `0x80000000`×`0x80000000` → `0x40000000`; MULH `0xFFFFFFFF`×`0xFFFFFFFF` → `0x00000000`.
- MULHSU `0xFFFFFFFF`×`0x00000002`:
  - With `X32_MUL_SIGNED_EN` → `0xFFFFFFFF`.
  - Without it → `0x00000001`.
- Hold `out_ready` low for 10 cycles after `out_valid` → `result` stable, `in_ready` 0, a new `in_valid` is not accepted; release → handshake, `in_ready` 1 next cycle.
- Assert `resetn` low 3 cycles after accept → `out_valid` 0 and `in_ready` 1 immediately. After release, MULHU `0x00010000`×`0x00010000` → `0x00000001`.
